// File: rtl/shift_pkg.sv
// Shared op codes, FSM states and dir-to-op mapping for the shift register control path.
package shift_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 2;
  localparam int unsigned DIR_W   = 2;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 3'b000;
  localparam op_t OP_LOAD = 3'b001;
  localparam op_t OP_LSL  = 3'b010;
  localparam op_t OP_LSR  = 3'b011;
  localparam op_t OP_ASR  = 3'b100;

  localparam logic [DIR_W-1:0] DIR_LSL     = 2'd0;
  localparam logic [DIR_W-1:0] DIR_LSR     = 2'd1;
  localparam logic [DIR_W-1:0] DIR_ASR     = 2'd2;
  localparam logic [DIR_W-1:0] DIR_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Map a request direction to its shift op; the invalid code falls back to LSL.
  function automatic op_t dir_to_op(input logic [DIR_W-1:0] dir);
    case (dir)
      DIR_LSL: dir_to_op = OP_LSL;
      DIR_LSR: dir_to_op = OP_LSR;
      DIR_ASR: dir_to_op = OP_ASR;
      default: dir_to_op = OP_LSL;
    endcase
  endfunction

endpackage

// File: rtl/shift_step_calc.sv
// Combinational step sizing: step = min(rem, STEP_MAX), remainder after that step.
module shift_step_calc
  import shift_pkg::*;
#(
  parameter int unsigned TOT_W    = 3,
  parameter int unsigned STEP_MAX = 3
) (
  input  logic [TOT_W-1:0]   rem,
  output logic [SHAMT_W-1:0] step_c,
  output logic [TOT_W-1:0]   rem_next_c
);

  // Clamp the step to STEP_MAX; subtraction cannot underflow since step <= rem.
  always_comb begin
    step_c = SHAMT_W'(rem);
    if (rem > TOT_W'(STEP_MAX)) begin
      step_c = SHAMT_W'(STEP_MAX);
    end
    rem_next_c = rem - TOT_W'(step_c);
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift command sequencer: expands one request into LOAD / shift command cycles.
// Optional feature macro: SHIFT_SEQ_ERR_EN (adds err output, rejects dir=3).
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned TOT_W    = 3,
  parameter int unsigned STEP_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_en,
  input  logic [DIR_W-1:0]   dir,
  input  logic [TOT_W-1:0]   total,
  output logic [OP_W-1:0]    op,
  output logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done
`ifdef SHIFT_SEQ_ERR_EN
  ,
  output logic               err
`endif
);

  state_t               st;
  logic [TOT_W-1:0]     rem;
  op_t                  dir_op;
  logic [TOT_W-1:0]     calc_in_c;
  logic [SHAMT_W-1:0]   step_c;
  logic [TOT_W-1:0]     rem_next_c;
  logic                 dir_bad_c;

  // In IDLE the first step is sized from the incoming total, afterwards from rem.
  always_comb begin
    calc_in_c = rem;
    if (st == ST_IDLE) begin
      calc_in_c = total;
    end
  end

  // Invalid direction only rejects the request when the error feature is built in.
  always_comb begin
`ifdef SHIFT_SEQ_ERR_EN
    dir_bad_c = (dir == DIR_INVALID);
`else
    dir_bad_c = 1'b0;
`endif
  end

  shift_step_calc #(
    .TOT_W    (TOT_W),
    .STEP_MAX (STEP_MAX)
  ) u_step (
    .rem        (calc_in_c),
    .step_c     (step_c),
    .rem_next_c (rem_next_c)
  );

  // FSM with registered outputs: outputs reflect the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= ST_IDLE;
      rem    <= '0;
      dir_op <= OP_LSL;
      op     <= OP_NOP;
      shamt  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SHIFT_SEQ_ERR_EN
      err    <= 1'b0;
`endif
    end else begin
      op    <= OP_NOP;
      shamt <= '0;
      done  <= 1'b0;
`ifdef SHIFT_SEQ_ERR_EN
      err   <= 1'b0;
`endif
      case (st)
        ST_IDLE: begin
          if (start) begin
            dir_op <= dir_to_op(dir);
            busy   <= 1'b1;
            if (dir_bad_c) begin
              rem  <= '0;
              st   <= ST_DONE;
              done <= 1'b1;
`ifdef SHIFT_SEQ_ERR_EN
              err  <= 1'b1;
`endif
            end else if (load_en) begin
              rem <= total;
              st  <= ST_LOAD;
              op  <= OP_LOAD;
            end else if (total != '0) begin
              rem   <= rem_next_c;
              st    <= ST_SHIFT;
              op    <= dir_to_op(dir);
              shamt <= step_c;
            end else begin
              rem  <= '0;
              st   <= ST_DONE;
              done <= 1'b1;
            end
          end
        end
        ST_LOAD, ST_SHIFT: begin
          if (rem != '0) begin
            rem   <= rem_next_c;
            st    <= ST_SHIFT;
            op    <= dir_op;
            shamt <= step_c;
          end else begin
            st   <= ST_DONE;
            done <= 1'b1;
          end
        end
        ST_DONE: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
        default: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: request-level model plus directed literal checks.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [2:0] total = 3'd0;
  logic [2:0] op;
  logic [1:0] shamt;
  logic       busy;
  logic       done;
  logic       err_v;
`ifdef SHIFT_SEQ_ERR_EN
  logic       err;
  assign err_v = err;
`else
  assign err_v = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] shamt;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t       q[$];
  exp_t       cur = '0;
  logic [4:0] cap[$];

  shift_seq_ctrl #(.TOT_W(3), .STEP_MAX(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .load_en (load_en),
    .dir     (dir),
    .total   (total),
    .op      (op),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done)
`ifdef SHIFT_SEQ_ERR_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] o, input logic [1:0] s,
                              input logic b, input logic d, input logic e);
    exp_t x;
    x.op = o; x.shamt = s; x.busy = b; x.done = d; x.err = e;
    return x;
  endfunction

  function automatic logic [2:0] exp_op(input logic [1:0] d);
    case (d)
      2'd1:    return 3'b011;
      2'd2:    return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  // Expected per-cycle outputs of one accepted request.
  task automatic build(input logic le, input logic [1:0] d, input int tot);
    int n;
`ifdef SHIFT_SEQ_ERR_EN
    if (d == 2'd3) begin
      q.push_back(mk(3'b000, 2'd0, 1'b1, 1'b1, 1'b1));
      return;
    end
`endif
    if (le) q.push_back(mk(3'b001, 2'd0, 1'b1, 1'b0, 1'b0));
    n = (tot + 2) / 3;
    for (int i = 0; i < n; i++) begin
      int amt;
      amt = (i == n - 1) ? tot - 3 * (n - 1) : 3;
      q.push_back(mk(exp_op(d), 2'(amt), 1'b1, 1'b0, 1'b0));
    end
    q.push_back(mk(3'b000, 2'd0, 1'b1, 1'b1, 1'b0));
  endtask

  // Model: accepts a request only when the expected output shows an idle controller.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      cur <= '0;
    end else if (q.size() != 0) begin
      cur <= q.pop_front();
    end else if (!cur.busy && start) begin
      build(load_en, dir, int'(total));
      cur <= q.pop_front();
    end else begin
      cur <= '0;
    end
  end

  // Per-cycle compare and command capture.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("cycle op/shamt/busy/done/err", 32'({op, shamt, busy, done, err_v}), 32'(cur));
        if (op != 3'b000) cap.push_back({op, shamt});
      end
    end
  end

  function automatic logic [4:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 5'h1F;
  endfunction

  task automatic issue(input logic le, input logic [1:0] d, input logic [2:0] t);
    load_en = le; dir = d; total = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " done seen"}, 32'(done), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int base;
    logic [7:0] sh;
    #1;
    chk("reset op", 32'(op), 32'd0);
    chk("reset shamt", 32'(shamt), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-SHIFT aborts immediately.
    issue(1'b0, 2'd0, 3'd7);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort op", 32'(op), 32'd0);
    chk("abort shamt", 32'(shamt), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); @(negedge clk);

    // LOAD then LSL/3, LSL/2.
    base = cap.size();
    issue(1'b1, 2'd0, 3'd5);
    wait_done("t2", 1, 4);
    chk("t2 count", 32'(cap.size() - base), 32'd3);
    chk("t2 cmd0", 32'(cap_at(base)), 32'({3'b001, 2'd0}));
    chk("t2 cmd1", 32'(cap_at(base + 1)), 32'({3'b010, 2'd3}));
    chk("t2 cmd2", 32'(cap_at(base + 2)), 32'({3'b010, 2'd2}));
    @(negedge clk);

    // ASR 7 on 0x80 saturates to 0xFF.
    base = cap.size();
    issue(1'b0, 2'd2, 3'd7);
    wait_done("t3", 1, 4);
    chk("t3 count", 32'(cap.size() - base), 32'd3);
    chk("t3 cmd0", 32'(cap_at(base)), 32'({3'b100, 2'd3}));
    chk("t3 cmd2", 32'(cap_at(base + 2)), 32'({3'b100, 2'd1}));
    sh = 8'h80;
    for (int i = base; i < cap.size(); i++)
      if (cap[i][4:2] == 3'b100) sh = 8'($signed(sh) >>> cap[i][1:0]);
    chk("t3 shifter", 32'(sh), 32'hFF);
    @(negedge clk);

    // Zero totals.
    base = cap.size();
    issue(1'b0, 2'd0, 3'd0);
    wait_done("t4a", 1, 1);
    chk("t4a count", 32'(cap.size() - base), 32'd0);
    @(negedge clk);
    base = cap.size();
    issue(1'b1, 2'd1, 3'd0);
    wait_done("t4b", 1, 2);
    chk("t4b count", 32'(cap.size() - base), 32'd1);
    chk("t4b cmd0", 32'(cap_at(base)), 32'({3'b001, 2'd0}));
    @(negedge clk);

    // Start while busy and during DONE ignored; start in IDLE accepted.
    base = cap.size();
    issue(1'b0, 2'd1, 3'd6);
    dir = 2'd0; total = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5a", 2, 3);
    dir = 2'd1; total = 3'd1; load_en = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("t5 idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done("t5b", 1, 2);
    chk("t5 count", 32'(cap.size() - base), 32'd3);
    chk("t5 cmd0", 32'(cap_at(base)), 32'({3'b011, 2'd3}));
    chk("t5 cmd1", 32'(cap_at(base + 1)), 32'({3'b011, 2'd3}));
    chk("t5 cmd2", 32'(cap_at(base + 2)), 32'({3'b011, 2'd1}));
    @(negedge clk);

    // dir=3 handling.
    base = cap.size();
    issue(1'b0, 2'd3, 3'd4);
`ifdef SHIFT_SEQ_ERR_EN
    wait_done("t6", 1, 1);
    chk("t6 err", 32'(err_v), 32'd1);
    chk("t6 count", 32'(cap.size() - base), 32'd0);
`else
    wait_done("t6", 1, 3);
    chk("t6 count", 32'(cap.size() - base), 32'd2);
    chk("t6 cmd0", 32'(cap_at(base)), 32'({3'b010, 2'd3}));
    chk("t6 cmd1", 32'(cap_at(base + 1)), 32'({3'b010, 2'd1}));
`endif
    @(negedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
